// File: rtl/hal_reset_sync.sv
// Reset synchroniser: async assert on arst, release after STAGES clk edges.
// Optional post-release stretch counter enabled by defining HAL_RESET_SYNC_STRETCH_EN.
module hal_reset_sync #(
    parameter int unsigned STAGES         = 2,
    parameter int unsigned STRETCH_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arst,
    output logic rst
);

    if (STAGES < 2 || STRETCH_CYCLES > 32'h0000_FFFF) begin : g_bad_param
        $error("hal_reset_sync: STAGES must be >= 2 and STRETCH_CYCLES <= 65535");
    end

    // Power-up value of 1 keeps rst asserted until the first valid release.
    logic [STAGES-1:0] chain = '1;
    logic              chain_out;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            chain <= '1;
        end else if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign chain_out = chain[STAGES-1];

`ifdef HAL_RESET_SYNC_STRETCH_EN
    localparam int unsigned CW = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(STRETCH_CYCLES);

    logic [CW-1:0] cnt = LOAD;

    // Counter is held at LOAD while the chain asserts, so it only begins
    // counting on the edge after the chain output has dropped.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt <= LOAD;
        end else if (!rst_n) begin
            cnt <= LOAD;
        end else if (chain_out) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign rst = chain_out | (cnt != '0);
`else
    assign rst = chain_out;
`endif

endmodule

// File: tb/tb_hal_reset_sync.sv
// Self-checking bench for hal_reset_sync; stretch case active when
// HAL_RESET_SYNC_STRETCH_EN is defined.
module tb_hal_reset_sync;

    localparam int unsigned STAGES = 2;
`ifdef HAL_RESET_SYNC_STRETCH_EN
    localparam int unsigned STRETCH = 4;
`else
    localparam int unsigned STRETCH = 0;
`endif
    // Edges from release until rst reads 0.
    localparam int unsigned LAT = STAGES + STRETCH;
    localparam int unsigned RA  = (LAT > 2) ? LAT - 2 : 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic arst  = 1'b1;
    logic rst;

    always #5 clk = ~clk;

    hal_reset_sync #(
        .STAGES        (STAGES),
        .STRETCH_CYCLES(STRETCH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .arst (arst),
        .rst  (rst)
    );

    typedef struct {
        string tag;
        logic  arst;
        logic  rst_n;
        logic  exp;
    } vec_t;

    vec_t vecs[$];
    logic exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: rst=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input string tag, input logic a, input logic r, input logic e);
        vec_t v;
        v.tag   = tag;
        v.arst  = a;
        v.rst_n = r;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    // Drive inputs 1 ns after an edge, sample 1 ns after the next edge.
    task automatic step(input string name, input logic a, input logic r, input logic e);
        logic want;
        arst  = a;
        rst_n = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(name, rst, want);
    endtask

    initial begin
        // Held in reset from t=0
        for (int unsigned k = 1; k <= 3; k++) add("hold_arst", 1'b1, 1'b1, 1'b1);
        // Release: rst stays 1 until edge LAT
        for (int unsigned k = 1; k <= LAT + 2; k++) add("release", 1'b0, 1'b1, (k < LAT) ? 1'b1 : 1'b0);
        // Local synchronous reset for one edge, then release again
        add("rst_n_load", 1'b0, 1'b0, 1'b1);
        for (int unsigned k = 1; k <= LAT + 1; k++) add("rst_n_release", 1'b0, 1'b1, (k < LAT) ? 1'b1 : 1'b0);
        // arst and rst_n together
        add("arst_and_rst_n", 1'b1, 1'b0, 1'b1);
        add("arst_and_rst_n", 1'b1, 1'b0, 1'b1);
        for (int unsigned k = 1; k <= LAT + 1; k++) add("release_2", 1'b0, 1'b1, (k < LAT) ? 1'b1 : 1'b0);

        #1;
        check("power_up", rst, 1'b1);

        for (int unsigned i = 0; i < vecs.size(); i++)
            step(vecs[i].tag, vecs[i].arst, vecs[i].rst_n, vecs[i].exp);

        // Async assert mid-cycle, no clock needed
        arst = 1'b1;
        #1;
        check("async_assert", rst, 1'b1);
        @(posedge clk);
        #1;
        check("async_hold", rst, 1'b1);

        // Release 1 ns after an edge: no async deassert, counts next edge as #1
        arst = 1'b0;
        #3;
        check("release_mid", rst, 1'b1);
        @(posedge clk);
        #1;
        check("release_e1", rst, (LAT > 1) ? 1'b1 : 1'b0);
        for (int unsigned k = 2; k <= LAT + 1; k++)
            step("release_tail", 1'b0, 1'b1, (k < LAT) ? 1'b1 : 1'b0);

        // Sub-cycle arst pulse is never lost
        arst = 1'b1;
        #2;
        arst = 1'b0;
        check("pulse_assert", rst, 1'b1);
        for (int unsigned k = 1; k <= LAT + 1; k++)
            step("pulse_release", 1'b0, 1'b1, (k < LAT) ? 1'b1 : 1'b0);

        // Re-assert mid-release: count restarts from scratch
        for (int unsigned k = 1; k <= 2; k++) step("pre_reassert", 1'b1, 1'b1, 1'b1);
        for (int unsigned k = 1; k <= RA; k++) step("partial_release", 1'b0, 1'b1, 1'b1);
        arst = 1'b1;
        #1;
        check("reassert", rst, 1'b1);
        #1;
        arst = 1'b0;
        @(posedge clk);
        #1;
        check("restart_e1", rst, 1'b1);
        for (int unsigned k = 2; k <= LAT + 1; k++)
            step("restart_tail", 1'b0, 1'b1, (k < LAT) ? 1'b1 : 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
